// File: rtl/tt_response_checker.sv
// tt_response_checker
//   Receive-side checker for exhaustive truth-table runs of a small
//   combinational DUT. A sequencer forwards (minterm index, sampled output)
//   pairs over a valid/ready link. Each response is compared against the
//   expected truth table TT. The block records mismatches, duplicate
//   minterms and ordering faults, and produces a registered pass/fail
//   verdict once every minterm has been seen.
//
// Parameters
//   N       number of DUT inputs (1..4); M = 2**N minterms
//   TT      expected truth table, bit m = expected output for minterm m
//   ORDERED 1 = minterms must arrive as 0,1,..,M-1
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        one-cycle pulse that begins a run (ignored mid-run)
//   in_valid     sender offers a response
//   in_m         minterm index that was applied to the DUT
//   in_s         DUT output sampled for in_m
//   in_ready     checker accepts a response (high for all of COLLECT)
//   busy         run in progress
//   done         verdict available
//   pass         verdict, meaningful only while done=1
//   err_mask     bit m set if minterm m mismatched
//   seen_mask    bit m set once minterm m has been accepted
//   err_count    number of mismatching minterms
//   dup_err      a minterm was received twice
//   ord_err      a minterm arrived out of sequence (ORDERED=1 only)
//   first_err_m  index of the first mismatching minterm
module tt_response_checker #(
  parameter int N = 2,
  localparam int M = 1 << N,
  parameter logic [M-1:0] TT = 4'b0001,
  parameter bit ORDERED = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  input  logic [N-1:0] in_m,
  input  logic         in_s,
  output logic         in_ready,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [M-1:0] err_mask,
  output logic [M-1:0] seen_mask,
  output logic [N:0]   err_count,
  output logic         dup_err,
  output logic         ord_err,
  output logic [N-1:0] first_err_m
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [N:0]   M_CNT   = (N + 1)'(M);
  localparam logic [M-1:0] ONE_BIT = {{(M - 1){1'b0}}, 1'b1};

  logic [1:0]   state;
  logic [N-1:0] exp_m;

  logic         xfer;
  logic [M-1:0] m_onehot;
  logic         is_dup;
  logic         mismatch;
  logic [M-1:0] seen_nxt;
  logic [M-1:0] err_mask_nxt;
  logic [N:0]   err_count_nxt;
  logic [N-1:0] first_err_nxt;
  logic         dup_nxt;
  logic         ord_nxt;

  // Next-state values of the result registers for an accepted transfer.
  // The verdict is formed from these so that done and pass can both be
  // presented on the same edge as the final transfer.
  always_comb begin
    xfer          = in_valid & in_ready;
    m_onehot      = ONE_BIT << in_m;
    is_dup        = |(seen_mask & m_onehot);
    mismatch      = (in_s != TT[in_m]);
    seen_nxt      = seen_mask;
    err_mask_nxt  = err_mask;
    err_count_nxt = err_count;
    first_err_nxt = first_err_m;
    dup_nxt       = dup_err;
    ord_nxt       = ord_err;
    if (is_dup) begin
      dup_nxt = 1'b1;
    end else begin
      seen_nxt = seen_mask | m_onehot;
      if (mismatch) begin
        err_mask_nxt = err_mask | m_onehot;
        // A zero count means no earlier mismatch in this run.
        if (err_count == '0) first_err_nxt = in_m;
        if (err_count != M_CNT) err_count_nxt = err_count + 1'b1;
      end
    end
    if (ORDERED && (in_m != exp_m)) ord_nxt = 1'b1;
  end

  // Run control and result registers. A start from IDLE or DONE wipes the
  // previous run; start in COLLECT is ignored. Completion is declared on
  // the edge where the seen mask becomes all ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      exp_m       <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_mask    <= '0;
      seen_mask   <= '0;
      err_count   <= '0;
      dup_err     <= 1'b0;
      ord_err     <= 1'b0;
      first_err_m <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (xfer) begin
            seen_mask   <= seen_nxt;
            err_mask    <= err_mask_nxt;
            err_count   <= err_count_nxt;
            first_err_m <= first_err_nxt;
            dup_err     <= dup_nxt;
            ord_err     <= ord_nxt;
            exp_m       <= exp_m + 1'b1;
            if (&seen_nxt) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              pass     <= (err_mask_nxt == '0) & ~dup_nxt & ~ord_nxt;
            end
          end
        end
        default: begin
          if (start) begin
            state       <= COLLECT;
            exp_m       <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_mask    <= '0;
            seen_mask   <= '0;
            err_count   <= '0;
            dup_err     <= 1'b0;
            ord_err     <= 1'b0;
            first_err_m <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_response_checker.sv
// tb_tt_response_checker
//   Drives two checkers from the same stimulus: one with ORDERED=1 and one
//   with ORDERED=0, both with the default N=2, TT=0001 (s = ~a & ~b).
//   Expected verdicts are queued per instance when a run is started; a
//   monitor pops one entry whenever an instance raises done.
module tb_tt_response_checker;

  typedef struct {
    string      name;
    logic       pass;
    logic [3:0] err_mask;
    logic [3:0] seen;
    logic [2:0] err_count;
    logic       dup;
    logic       ord;
    logic [1:0] first;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [1:0] in_m;
  logic       in_s;

  logic       o_in_ready, o_busy, o_done, o_pass, o_dup, o_ord;
  logic [3:0] o_err_mask, o_seen;
  logic [2:0] o_err_count;
  logic [1:0] o_first;

  logic       u_in_ready, u_busy, u_done, u_pass, u_dup, u_ord;
  logic [3:0] u_err_mask, u_seen;
  logic [2:0] u_err_count;
  logic [1:0] u_first;

  logic       o_done_q;
  logic       u_done_q;

  exp_t q_o[$];
  exp_t q_u[$];

  int checks;
  int fails;

  tt_response_checker #(.N(2), .TT(4'b0001), .ORDERED(1'b1)) dut_ord (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_m(in_m), .in_s(in_s), .in_ready(o_in_ready), .busy(o_busy),
    .done(o_done), .pass(o_pass), .err_mask(o_err_mask),
    .seen_mask(o_seen), .err_count(o_err_count), .dup_err(o_dup),
    .ord_err(o_ord), .first_err_m(o_first)
  );

  tt_response_checker #(.N(2), .TT(4'b0001), .ORDERED(1'b0)) dut_unord (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_m(in_m), .in_s(in_s), .in_ready(u_in_ready), .busy(u_busy),
    .done(u_done), .pass(u_pass), .err_mask(u_err_mask),
    .seen_mask(u_seen), .err_count(u_err_count), .dup_err(u_dup),
    .ord_err(u_ord), .first_err_m(u_first)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Drives one cycle of inputs, returns 1ns after the sampling edge.
  task automatic applyStimulus(input logic v, input logic [1:0] m,
                               input logic s, input logic st);
    in_valid = v;
    in_m     = m;
    in_s     = s;
    start    = st;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic sendXfer(input logic [1:0] m, input logic s);
    applyStimulus(1'b1, m, s, 1'b0);
  endtask

  task automatic pushExp(input string name, input logic po, input logic pu,
                         input logic [3:0] em, input logic [2:0] cnt,
                         input logic dup, input logic oo, input logic [1:0] fe);
    exp_t e;
    e.name = name; e.err_mask = em; e.seen = 4'hF; e.err_count = cnt;
    e.dup = dup; e.first = fe;
    e.pass = po; e.ord = oo;
    q_o.push_back(e);
    e.pass = pu; e.ord = 1'b0;
    q_u.push_back(e);
  endtask

  task automatic compareVerdict(input string tag, input exp_t e,
                                input logic p, input logic [3:0] em,
                                input logic [3:0] sm, input logic [2:0] cnt,
                                input logic d, input logic o,
                                input logic [1:0] fe);
    checkOutput({tag, e.name, ".pass"}, 32'(p), 32'(e.pass));
    checkOutput({tag, e.name, ".err_mask"}, 32'(em), 32'(e.err_mask));
    checkOutput({tag, e.name, ".seen_mask"}, 32'(sm), 32'(e.seen));
    checkOutput({tag, e.name, ".err_count"}, 32'(cnt), 32'(e.err_count));
    checkOutput({tag, e.name, ".dup_err"}, 32'(d), 32'(e.dup));
    checkOutput({tag, e.name, ".ord_err"}, 32'(o), 32'(e.ord));
    if (e.err_mask != 4'h0)
      checkOutput({tag, e.name, ".first_err_m"}, 32'(fe), 32'(e.first));
  endtask

  // Monitor: each rising done is matched against the oldest queued verdict.
  always @(negedge clk) begin
    if (o_done && !o_done_q) begin
      if (q_o.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL ord.unexpected_done: got done=1 expected no verdict");
      end else begin
        compareVerdict("ord.", q_o.pop_front(), o_pass, o_err_mask, o_seen,
                       o_err_count, o_dup, o_ord, o_first);
      end
    end
    if (u_done && !u_done_q) begin
      if (q_u.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL unord.unexpected_done: got done=1 expected no verdict");
      end else begin
        compareVerdict("unord.", q_u.pop_front(), u_pass, u_err_mask, u_seen,
                       u_err_count, u_dup, u_ord, u_first);
      end
    end
    o_done_q <= o_done;
    u_done_q <= u_done;
  end

  task automatic checkAllZero(input string name);
    checkOutput({name, ".ord_outputs"},
                32'({o_in_ready, o_busy, o_done, o_pass, o_err_mask, o_seen,
                     o_err_count, o_dup, o_ord, o_first}), 32'h0);
    checkOutput({name, ".unord_outputs"},
                32'({u_in_ready, u_busy, u_done, u_pass, u_err_mask, u_seen,
                     u_err_count, u_dup, u_ord, u_first}), 32'h0);
  endtask

  task automatic cleanRun();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    sendXfer(2'd0, 1'b1);
    sendXfer(2'd1, 1'b0);
    sendXfer(2'd2, 1'b0);
    sendXfer(2'd3, 1'b0);
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    o_done_q = 1'b0;
    u_done_q = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_m     = 2'd0;
    in_s     = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    checkAllZero("reset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

    // Clean run; start coincides with a response in IDLE, start wins.
    pushExp("clean", 1'b1, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b1);
    checkOutput("start.busy", 32'(o_busy), 32'd1);
    checkOutput("start.in_ready", 32'(o_in_ready), 32'd1);
    checkOutput("start.no_capture", 32'(o_seen), 32'h0);
    sendXfer(2'd0, 1'b1);
    sendXfer(2'd1, 1'b0);
    sendXfer(2'd2, 1'b0);
    checkOutput("clean.done_early", 32'(o_done), 32'd0);
    checkOutput("clean.seen_partial", 32'(o_seen), 32'h7);
    sendXfer(2'd3, 1'b0);
    checkOutput("clean.done", 32'(o_done), 32'd1);
    checkOutput("clean.in_ready_off", 32'(o_in_ready), 32'd0);
    checkOutput("clean.busy_off", 32'(o_busy), 32'd0);
    // A response offered in DONE must be ignored.
    sendXfer(2'd0, 1'b0);
    checkOutput("done.no_capture_err", 32'(o_err_mask), 32'h0);
    checkOutput("done.hold_pass", 32'(o_pass), 32'd1);

    // Minterm 2 answered with s=1.
    pushExp("bad2", 1'b0, 1'b0, 4'b0100, 3'd1, 1'b0, 1'b0, 2'd2);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    sendXfer(2'd0, 1'b1);
    sendXfer(2'd1, 1'b0);
    sendXfer(2'd2, 1'b1);
    sendXfer(2'd3, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

    // Duplicate minterm 1; the extra transfer also breaks the ordering.
    pushExp("dup", 1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 1'b1, 2'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    sendXfer(2'd0, 1'b1);
    sendXfer(2'd1, 1'b0);
    sendXfer(2'd1, 1'b0);
    sendXfer(2'd2, 1'b0);
    checkOutput("dup.done_early", 32'(o_done), 32'd0);
    sendXfer(2'd3, 1'b0);
    checkOutput("dup.done", 32'(o_done), 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

    // Out-of-order 1,0,2,3 with correct values.
    pushExp("order", 1'b0, 1'b1, 4'h0, 3'd0, 1'b0, 1'b1, 2'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    sendXfer(2'd1, 1'b0);
    sendXfer(2'd0, 1'b1);
    sendXfer(2'd2, 1'b0);
    sendXfer(2'd3, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

    // Every minterm wrong: count reaches M.
    pushExp("allbad", 1'b0, 1'b0, 4'hF, 3'd4, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    sendXfer(2'd0, 1'b0);
    sendXfer(2'd1, 1'b1);
    sendXfer(2'd2, 1'b1);
    sendXfer(2'd3, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

    // Reset in the middle of a run, then a clean run.
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    sendXfer(2'd0, 1'b0);
    sendXfer(2'd1, 1'b0);
    checkOutput("abort.seen", 32'(o_seen), 32'h3);
    checkOutput("abort.err_mask", 32'(o_err_mask), 32'h1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    checkAllZero("midreset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    pushExp("postreset", 1'b1, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 2'd0);
    cleanRun();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

    // Gappy valid 1,0,0,1,1,0,1 with a stray start pulse in a gap.
    pushExp("gaps", 1'b1, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    sendXfer(2'd0, 1'b1);
    applyStimulus(1'b0, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd1, 1'b1, 1'b1);
    checkOutput("gaps.seen_hold", 32'(o_seen), 32'h1);
    checkOutput("gaps.busy", 32'(o_busy), 32'd1);
    sendXfer(2'd1, 1'b0);
    sendXfer(2'd2, 1'b0);
    applyStimulus(1'b0, 2'd3, 1'b1, 1'b0);
    checkOutput("gaps.done_early", 32'(o_done), 32'd0);
    checkOutput("gaps.seen_partial", 32'(o_seen), 32'h7);
    sendXfer(2'd3, 1'b0);
    checkOutput("gaps.done", 32'(u_done), 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

    checkOutput("ord.verdicts_left", 32'(q_o.size()), 32'd0);
    checkOutput("unord.verdicts_left", 32'(q_u.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
